// File: rtl/jcc_sequencer_pkg.sv
// Shared types and constants for the short conditional branch / INTO sequencer.
package jcc_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISP     = 3'd1,
    S_EVAL     = 3'd2,
    S_REDIRECT = 3'd3,
    S_TRAP     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;
  localparam int FLAG_OF = 11;

  localparam logic [7:0] JCC_BASE = 8'h70;
  localparam logic [7:0] OP_INTO  = 8'hCE;

  typedef struct packed {
    state_t state;
    logic   taken;
  } dbg_t;

  function automatic logic is_jcc(input logic [7:0] op);
    return op[7:4] == JCC_BASE[7:4];
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/jcc_sequencer_jumptest.sv
// Condition evaluation for Jcc 0x70-0x7F and INTO; purely combinational.
module jcc_sequencer_jumptest
  import jcc_sequencer_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [15:0] flags,
  output logic        taken
);

  logic cf, pf, zf, sf, of_f;
  logic cond;
  logic unused_flags;

  assign cf   = flags[FLAG_CF];
  assign pf   = flags[FLAG_PF];
  assign zf   = flags[FLAG_ZF];
  assign sf   = flags[FLAG_SF];
  assign of_f = flags[FLAG_OF];
  assign unused_flags = ^{flags[15:12], flags[10:8], flags[5:3], flags[1]};

  // opcode[3:1] selects the base test, opcode[0] inverts it
  always_comb begin
    cond = 1'b0;
    case (opcode[3:1])
      3'd0: cond = of_f;
      3'd1: cond = cf;
      3'd2: cond = zf;
      3'd3: cond = cf | zf;
      3'd4: cond = sf;
      3'd5: cond = pf;
      3'd6: cond = sf ^ of_f;
      3'd7: cond = (sf ^ of_f) | zf;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    if (opcode == OP_INTO) begin
      taken = of_f;
    end else if (is_jcc(opcode)) begin
      taken = cond ^ opcode[0];
    end
  end

endmodule

// File: rtl/jcc_sequencer.sv
// Sequencer for short conditional jumps and INTO: fetch rel8, evaluate, redirect or trap.
// Handshakes: a transfer happens on any cycle where valid/req and ready/ack are both high;
// the request side holds its payload stable until then. fifo_rd_en pops the FWFT head.
module jcc_sequencer
  import jcc_sequencer_pkg::*;
#(
  parameter logic [7:0] INTO_VECTOR = 8'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [15:0] flags,
  input  logic [15:0] ip,
  input  logic        abort,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [15:0] redirect_ip,
  output logic        int_req,
  output logic [7:0]  int_vector,
  input  logic        int_ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] next_ip,
  output dbg_t        dbg
);

  state_t      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] flags_q, flags_d;
  logic [15:0] ip_q, ip_d;
  logic [7:0]  disp_q, disp_d;
  logic        taken_q, taken_d;
  logic [15:0] redirect_ip_q, redirect_ip_d;
  logic [15:0] next_ip_q, next_ip_d;
  logic        jt_taken;

  jcc_sequencer_jumptest u_jumptest (
    .opcode (opcode_q),
    .flags  (flags_q),
    .taken  (jt_taken)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      opcode_q      <= '0;
      flags_q       <= '0;
      ip_q          <= '0;
      disp_q        <= '0;
      taken_q       <= 1'b0;
      redirect_ip_q <= '0;
      next_ip_q     <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      flags_q       <= flags_d;
      ip_q          <= ip_d;
      disp_q        <= disp_d;
      taken_q       <= taken_d;
      redirect_ip_q <= redirect_ip_d;
      next_ip_q     <= next_ip_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    flags_d       = flags_q;
    ip_d          = ip_q;
    disp_d        = disp_q;
    taken_d       = taken_q;
    redirect_ip_d = redirect_ip_q;
    next_ip_d     = next_ip_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opcode_d = opcode;
          flags_d  = flags;
          ip_d     = ip;
          if (is_jcc(opcode)) begin
            state_d = S_DISP;
          end else if (opcode == OP_INTO) begin
            state_d = S_EVAL;
          end else begin
            state_d   = S_DONE;
            next_ip_d = ip;
          end
        end
      end
      S_DISP: begin
        if (!fifo_empty) begin
          disp_d  = fifo_data;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        taken_d = jt_taken;
        if (opcode_q == OP_INTO) begin
          if (jt_taken) begin
            state_d = S_TRAP;
          end else begin
            state_d   = S_DONE;
            next_ip_d = ip_q;
          end
        end else if (jt_taken) begin
          state_d       = S_REDIRECT;
          redirect_ip_d = ip_q + 16'd1 + sext8(disp_q);
        end else begin
          state_d   = S_DONE;
          next_ip_d = ip_q + 16'd1;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) begin
          state_d   = S_DONE;
          next_ip_d = redirect_ip_q;
        end
      end
      S_TRAP: begin
        if (int_ack) begin
          state_d   = S_DONE;
          next_ip_d = ip_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A coincident handshake still completes upstream, but its result is dropped here
    if (abort) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    fifo_rd_en     = (state_q == S_DISP) && !fifo_empty;
    redirect_valid = (state_q == S_REDIRECT);
    int_req        = (state_q == S_TRAP);
    int_vector     = (state_q == S_TRAP) ? INTO_VECTOR : 8'd0;
    busy           = (state_q != S_IDLE);
    done           = (state_q == S_DONE);
  end

  assign redirect_ip = redirect_ip_q;
  assign next_ip     = next_ip_q;
  assign dbg         = '{state: state_q, taken: taken_q};

endmodule
